regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single register-file write port (we/wa/wd) among NUM_REQ writeback
//   requesters, e.g. ALU result, load return and CSR/MMIO return.
//   - Valid/ready handshake on each requester; round-robin arbitration.
//   - One registered output stage drives the regfile write port.
//   - Sits between the writeback sources and the 32x32 register file.
// PARAMETERS
//   NUM_REQ  2   number of requesters (legal 2..4)
//   DATA_W   32  write data width
//   ADDR_W   5   register address width
// PORTS
//   clk           in   1               clock; all state updates on posedge
//   rst_n         in   1               asynchronous, active-low reset
//   req_valid     in   NUM_REQ         requester i has a write pending
//   req_ready     out  NUM_REQ         requester i accepted this cycle (one-hot or 0)
//   req_addr      in   NUM_REQ*ADDR_W  dest reg, requester i at [i*ADDR_W +: ADDR_W]
//   req_data      in   NUM_REQ*DATA_W  write data, requester i at [i*DATA_W +: DATA_W]
//   rf_we         out  1               regfile write enable (registered)
//   rf_wa         out  ADDR_W          regfile write address (registered)
//   rf_wd         out  DATA_W          regfile write data (registered)
//   grant_id      out  2               index of requester accepted last cycle (registered)
//   conflict_cnt  out  16              saturating count of cycles with >=2 valid requests
//   byp_ra1/2     in   ADDR_W          [WB_BYPASS_EN only] regfile read addresses
//   byp_hit1/2    out  1               [WB_BYPASS_EN only] in-flight write matches ra
//   byp_data1/2   out  DATA_W          [WB_BYPASS_EN only] forwarded data (rf_wd)
// BEHAVIOUR
//   - Reset (async, rst_n=0): rf_we=0, rf_wa=0, rf_wd=0, grant_id=0, conflict_cnt=0,
//     rr_ptr=0. req_ready is combinational and is 0 while in reset.
//   - Arbitration, combinational each cycle:
//     - Search valid requesters starting at rr_ptr, ascending with wrap.
//     - First hit i gets req_ready[i]=1; all others 0; none valid -> all 0.
//   - Acceptance = req_valid[i] & req_ready[i]. On acceptance at edge N:
//     - rf_wa <= addr_i, rf_wd <= data_i.
//     - rf_we <= (addr_i != 0).
//     - grant_id <= i, rr_ptr <= (i+1) mod NUM_REQ.
//   - No acceptance: rf_we <= 0; rf_wa/rf_wd/grant_id/rr_ptr hold.
//   - Latency: accept at edge N -> regfile written at edge N+1. Throughput 1 write/cycle.
//     The output stage never back-pressures (the regfile always accepts).
//   - r0 writes: handshake completes normally; rf_we stays 0, so r0 is never written.
//   - Requester rule: once valid=1, addr/data stay stable and valid stays high until
//     accepted. Violation is a requester bug, not handled here.
//   - Starvation bound: a continuously valid requester is accepted within NUM_REQ cycles.
//   - Same-address conflict: both are written in grant order; the later grant wins.
//   - conflict_cnt: +1 on each edge where popcount(req_valid) >= 2; saturates at 16'hFFFF.
//   - Reset mid-operation: the registered write is discarded (rf_we forced 0).
//     The requester already saw its handshake complete, so that write is lost by design.
// CONFIGURATION
//   WB_BYPASS_EN defined:
//     - Adds the byp_* ports.
//     - byp_hitK = rf_we & (rf_wa == byp_raK) & (byp_raK != 0); byp_dataK = rf_wd.
//     - Combinational; lets decode read the value written on this edge.
//   WB_BYPASS_EN undefined: byp_* ports absent; no forwarding logic.
// TESTING
//   1. Reset: rst_n=0 mid-stream with rf_we=1 -> rf_we/rf_wa/rf_wd/grant_id/conflict_cnt=0
//      immediately (async); rr_ptr=0, so first grant after release goes to req0.
//   2. Single requester: req1 valid, addr=5, data=32'hDEADBEEF ->
//      - req_ready=2'b10 the same cycle;
//      - next cycle rf_we=1, rf_wa=5, rf_wd=32'hDEADBEEF, grant_id=1.
//   3. Contention: req0 and req1 valid 4 cycles, stable -> grants alternate 0,1,0,1;
//      conflict_cnt increments while both are pending.
//   4. r0 write: req0 valid, addr=0, data=32'h1234 -> req_ready[0]=1;
//      next cycle rf_we=0, grant_id=0.
//   5. Back-to-back: req0 valid 3 cycles, new addr/data each accept ->
//      rf_we=1 for 3 consecutive cycles, in order, no bubbles.
//   6. WB_BYPASS_EN: in-flight rf_wa=7, rf_wd=32'hA5A5A5A5, byp_ra1=7, byp_ra2=0 ->
//      byp_hit1=1, byp_data1=32'hA5A5A5A5, byp_hit2=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port among NUM_REQ writeback
// requesters (ALU result, load return, CSR/MMIO return, ...). Each requester
// uses a valid/ready handshake. A round-robin arbiter picks one requester per
// cycle, and one registered output stage drives the regfile write port.
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, this adds read-address inputs and forwarding outputs. Decode
//   can then see the value that the regfile is writing on this edge.
//
// Parameters
//   NUM_REQ  number of requesters (2..4)
//   DATA_W   write data width
//   ADDR_W   register address width
//
// Ports
//   clk           clock; all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   req_valid     per-requester write pending
//   req_ready     per-requester accept strobe (one-hot or zero, combinational)
//   req_addr      packed destination registers, requester i at [i*ADDR_W +: ADDR_W]
//   req_data      packed write data, requester i at [i*DATA_W +: DATA_W]
//   rf_we         registered regfile write enable
//   rf_wa         registered regfile write address
//   rf_wd         registered regfile write data
//   grant_id      index of the requester accepted on the previous edge
//   conflict_cnt  saturating count of cycles with two or more valid requests
//   byp_ra1/2     (WB_BYPASS_EN) regfile read addresses
//   byp_hit1/2    (WB_BYPASS_EN) in-flight write matches the read address
//   byp_data1/2   (WB_BYPASS_EN) forwarded write data
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_wa,
  output logic [DATA_W-1:0]         rf_wd,
  output logic [1:0]                grant_id,
`ifdef WB_BYPASS_EN
  input  logic [ADDR_W-1:0]         byp_ra1,
  input  logic [ADDR_W-1:0]         byp_ra2,
  output logic                      byp_hit1,
  output logic                      byp_hit2,
  output logic [DATA_W-1:0]         byp_data1,
  output logic [DATA_W-1:0]         byp_data2,
`endif
  output logic [15:0]               conflict_cnt
);

  logic [1:0]        rr_ptr;
  logic [1:0]        sel;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [2:0]        cand;
  logic              found;
  logic [2:0]        valid_count;
  logic              multi_valid;

  // Round-robin search. Candidate k is (rr_ptr + k) wrapped at NUM_REQ.
  // The first valid candidate wins. Ready is held low during reset so that
  // no requester sees a handshake that would then be dropped.
  always_comb begin
    req_ready = '0;
    sel       = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + 3'(k);
      if (cand >= 3'(NUM_REQ)) begin
        cand = cand - 3'(NUM_REQ);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && rst_n && (3'(i) == cand) && req_valid[i]) begin
          req_ready[i] = 1'b1;
          sel          = 2'(i);
          found        = 1'b1;
        end
      end
    end
  end

  assign accept = |req_ready;

  // Payload mux driven by the one-hot ready vector.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Population count of the valid requests, used for contention statistics.
  always_comb begin
    valid_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      valid_count = valid_count + {2'b00, req_valid[i]};
    end
  end

  assign multi_valid = (valid_count >= 3'd2);

  // Output stage. A write to r0 still completes its handshake, but the write
  // enable is suppressed so that r0 is never modified. With no acceptance,
  // only the enable drops and the rest holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_wa    <= '0;
      rf_wd    <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      rf_we    <= (sel_addr != '0);
      rf_wa    <= sel_addr;
      rf_wd    <= sel_data;
      grant_id <= sel;
      rr_ptr   <= (sel == 2'(NUM_REQ-1)) ? 2'd0 : sel + 2'd1;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Contention counter; it saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (multi_valid && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the write that is landing in the regfile on this edge. r0 reads
  // never hit because r0 is hardwired to zero.
  assign byp_hit1  = rf_we && (rf_wa == byp_ra1) && (byp_ra1 != '0);
  assign byp_hit2  = rf_we && (rf_wa == byp_ra2) && (byp_ra2 != '0);
  assign byp_data1 = rf_wd;
  assign byp_data2 = rf_wd;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed bench for regfile_wb_arbiter with two requesters. Inputs change
// 1 ns after the rising edge. Combinational outputs are read 1 ns after that.
// Registered outputs are read 1 ns after the edge that updates them.
// Optional macro: WB_BYPASS_EN enables the forwarding checks.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_wa;
  logic [DATA_W-1:0]         rf_wd;
  logic [1:0]                grant_id;
  logic [15:0]               conflict_cnt;
`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0]         byp_ra1;
  logic [ADDR_W-1:0]         byp_ra2;
  logic                      byp_hit1;
  logic                      byp_hit2;
  logic [DATA_W-1:0]         byp_data1;
  logic [DATA_W-1:0]         byp_data2;
`endif

  int total;
  int bad;

  regfile_wb_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .grant_id    (grant_id),
`ifdef WB_BYPASS_EN
    .byp_ra1     (byp_ra1),
    .byp_ra2     (byp_ra2),
    .byp_hit1    (byp_hit1),
    .byp_hit2    (byp_hit2),
    .byp_data1   (byp_data1),
    .byp_data2   (byp_data2),
`endif
    .conflict_cnt(conflict_cnt)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives both requesters, then waits 1 ns so the combinational ready is visible.
  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [4:0] a0, input logic [31:0] d0,
                               input logic [4:0] a1, input logic [31:0] d1);
    req_valid = valid;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    #1;
  endtask

  // Advances to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the registered write port.
  task automatic checkWrite(input string tag, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic [1:0] gid);
    checkOutput({tag, "_we"},  32'(rf_we),    32'(we));
    checkOutput({tag, "_wa"},  32'(rf_wa),    32'(wa));
    checkOutput({tag, "_wd"},  rf_wd,         wd);
    checkOutput({tag, "_gid"}, 32'(grant_id), 32'(gid));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
`ifdef WB_BYPASS_EN
    byp_ra1 = '0;
    byp_ra2 = '0;
`endif

    // Reset values, with requests pending to show that ready is gated in reset.
    applyStimulus(2'b11, 5'd1, 32'h11, 5'd2, 32'h22);
    checkOutput("rst_ready", 32'(req_ready), 32'h0);
    checkWrite("rst", 1'b0, 5'd0, 32'h0, 2'd0);
    checkOutput("rst_cnt", 32'(conflict_cnt), 32'h0);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single requester.
    applyStimulus(2'b10, 5'd0, 32'h0, 5'd5, 32'hDEADBEEF);
    checkOutput("single_ready", 32'(req_ready), 32'h2);
    tick();
    checkWrite("single", 1'b1, 5'd5, 32'hDEADBEEF, 2'd1);
    checkOutput("single_cnt", 32'(conflict_cnt), 32'h0);

    // Contention: stable requests, grants alternate starting at req0.
    applyStimulus(2'b11, 5'd3, 32'h30, 5'd4, 32'h40);
    for (int c = 0; c < 4; c++) begin
      checkOutput("cont_ready", 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      if (c % 2 == 0) checkWrite("cont", 1'b1, 5'd3, 32'h30, 2'd0);
      else            checkWrite("cont", 1'b1, 5'd4, 32'h40, 2'd1);
      checkOutput("cont_cnt", 32'(conflict_cnt), 32'(c + 1));
    end
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    checkWrite("idle", 1'b0, 5'd4, 32'h40, 2'd1);
    checkOutput("idle_cnt", 32'(conflict_cnt), 32'd4);

    // Write to r0: the handshake completes but the write enable stays low.
    applyStimulus(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0);
    checkOutput("r0_ready", 32'(req_ready), 32'h1);
    tick();
    checkWrite("r0", 1'b0, 5'd0, 32'h1234, 2'd0);

    // Back-to-back writes from req0 with no bubbles.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(2'b01, 5'(10 + c), 32'(256 + c), 5'd0, 32'h0);
      checkOutput("b2b_ready", 32'(req_ready), 32'h1);
      tick();
      checkWrite("b2b", 1'b1, 5'(10 + c), 32'(256 + c), 2'd0);
    end
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    checkOutput("b2b_end_we", 32'(rf_we), 32'h0);

`ifdef WB_BYPASS_EN
    // Forwarding of the in-flight write.
    applyStimulus(2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'h0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    byp_ra1 = 5'd7;
    byp_ra2 = 5'd0;
    #1;
    checkOutput("byp_hit1",  32'(byp_hit1), 32'h1);
    checkOutput("byp_data1", byp_data1,     32'hA5A5A5A5);
    checkOutput("byp_hit2",  32'(byp_hit2), 32'h0);
    tick();
    checkOutput("byp_hit1_idle", 32'(byp_hit1), 32'h0);
`endif

    // Reset mid-stream. rr_ptr is 1 here, so a grant to req0 afterwards
    // proves that the pointer was reset.
    applyStimulus(2'b01, 5'd9, 32'h99, 5'd0, 32'h0);
    tick();
    checkWrite("pre_rst", 1'b1, 5'd9, 32'h99, 2'd0);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    rst_n = 1'b0;
    #1;
    checkWrite("mid_rst", 1'b0, 5'd0, 32'h0, 2'd0);
    checkOutput("mid_rst_cnt", 32'(conflict_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus(2'b11, 5'd1, 32'h111, 5'd2, 32'h222);
    checkOutput("post_rst_ready", 32'(req_ready), 32'h1);
    tick();
    checkWrite("post_rst", 1'b1, 5'd1, 32'h111, 2'd0);

    // Saturation of the contention counter (one count already taken above).
    repeat (65540) @(posedge clk);
    #1;
    checkOutput("cnt_sat", 32'(conflict_cnt), 32'h0000FFFF);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    checkOutput("cnt_hold", 32'(conflict_cnt), 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
